m_006_down_counter: RTL and testbench

M_006_DOWN_COUNTER -- requirements
Module: m_006_down_counter

---
 rtl/m_006_down_counter.sv | 99 +++++++++
 tb/tb_m_006_down_counter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/m_006_down_counter.sv
// m_006_down_counter
// Loadable down-counter with a two-state IDLE/RUN controller and a registered
// terminal-count pulse. A load with a non-zero value starts or restarts a
// countdown. A load of zero ends in IDLE and pulses tc at once.
// Optional feature macro: DOWN_COUNTER_AUTORELOAD_EN. When it is defined, the
// counter reloads the last loaded value after reaching zero instead of stopping.
// All outputs come straight from registers; reset is synchronous, active-low.

module m_006_down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             n_rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             tc_o,
   output logic             busy_o
);

   // Reject widths outside the supported range at elaboration time
   if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("m_006_down_counter: WIDTH must be in 2..16");
   end

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

   state_t           state_reg;
   logic [WIDTH-1:0] cnt_reg;
   logic             tc_reg;

`ifdef DOWN_COUNTER_AUTORELOAD_EN
   // Holds the most recently accepted load value so a period can restart
   logic [WIDTH-1:0] reload_reg;

   // Reload register: cleared by reset and captured on every accepted load
   always_ff @(posedge clk_i) begin
      if (!n_rst_i) begin
         reload_reg <= CNT_ZERO;
      end else if (load_i) begin
         reload_reg <= load_val_i;
      end
   end
`endif

   // Controller and counter: reset beats load, and load beats enable
   always_ff @(posedge clk_i) begin
      if (!n_rst_i) begin
         state_reg <= IDLE;
         cnt_reg   <= CNT_ZERO;
         tc_reg    <= 1'b0;
      end else begin
         // tc is a one-cycle pulse; only the terminal branches raise it
         tc_reg <= 1'b0;
         if (load_i) begin
            cnt_reg <= load_val_i;
            if (load_val_i == CNT_ZERO) begin
               state_reg <= IDLE;
               tc_reg    <= 1'b1;
            end else begin
               state_reg <= RUN;
            end
         end else if (state_reg == RUN && en_i) begin
            if (cnt_reg > CNT_ONE) begin
               cnt_reg <= cnt_reg - CNT_ONE;
            end else if (cnt_reg == CNT_ONE) begin
               cnt_reg <= CNT_ZERO;
               tc_reg  <= 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
               state_reg <= RUN;
`else
               state_reg <= IDLE;
`endif
            end else begin
               // Count is zero while running: the start of a new auto-reload
               // period. This cannot occur without auto-reload; the fallback
               // parks in IDLE so the counter never wraps.
`ifdef DOWN_COUNTER_AUTORELOAD_EN
               cnt_reg <= reload_reg;
`else
               state_reg <= IDLE;
`endif
            end
         end
      end
   end

   assign cnt_o  = cnt_reg;
   assign tc_o   = tc_reg;
   assign busy_o = (state_reg == RUN);

endmodule

// File: tb/tb_m_006_down_counter.sv
// Testbench for m_006_down_counter (WIDTH=4).
// A behavioural model tracks what the outputs must be after every edge. One
// process compares the DUT against that model. Directed sequences then pin the
// model with hand-written expected values, and a randomized phase follows.
// The bench follows DOWN_COUNTER_AUTORELOAD_EN in the same way as the design.

module tb_m_006_down_counter;

   localparam int WIDTH = 4;

   logic             clk_i = 1'b0;
   logic             n_rst_i = 1'b0;
   logic             load_i = 1'b0;
   logic [WIDTH-1:0] load_val_i = '0;
   logic             en_i = 1'b0;
   logic [WIDTH-1:0] cnt_o;
   logic             tc_o;
   logic             busy_o;

   int cmp_count = 0;
   int err_count = 0;

   m_006_down_counter #(.WIDTH(WIDTH)) dut (
      .clk_i      (clk_i),
      .n_rst_i    (n_rst_i),
      .load_i     (load_i),
      .load_val_i (load_val_i),
      .en_i       (en_i),
      .cnt_o      (cnt_o),
      .tc_o       (tc_o),
      .busy_o     (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Model state: remaining count, running flag, pulse and the last loaded value
   int  m_cnt = 0;
   bit  m_run = 0;
   bit  m_tc = 0;
   int  m_reload = 0;
   bit  m_valid = 0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   task automatic chk(input string name, input int act, input int exp);
      cmp_count++;
      if (act != exp) begin
         err_count++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model update on each edge, then a comparison 1 time unit later
   always @(posedge clk_i) begin
      if (!n_rst_i) begin
         m_cnt = 0; m_run = 0; m_tc = 0; m_reload = 0; m_valid = 1;
      end else if (load_i) begin
         m_reload = int'(load_val_i);
         m_cnt    = m_reload;
         m_run    = (m_reload != 0);
         m_tc     = (m_reload == 0);
      end else if (m_run && en_i) begin
         // One more enabled step of a countdown from m_reload to 0
         m_tc = (m_cnt == 1);
         if (m_cnt == 0) m_cnt = m_reload;
         else            m_cnt = m_cnt - 1;
         if (m_tc && !AUTO) m_run = 0;
      end else begin
         m_tc = 0;
      end
      #1;
      if (m_valid) begin
         chk("model_cnt",  int'(cnt_o),  m_cnt);
         chk("model_tc",   int'(tc_o),   int'(m_tc));
         chk("model_busy", int'(busy_o), int'(m_run));
      end
   end

   // Drive one cycle of inputs and return just after the model comparison
   task automatic cyc(input bit rst_n, input bit ld, input int val, input bit en);
      @(negedge clk_i);
      n_rst_i    = rst_n;
      load_i     = ld;
      load_val_i = WIDTH'(val);
      en_i       = en;
      @(posedge clk_i);
      #2;
   endtask

   task automatic pin(input string name, input int c, input int t, input int b);
      chk({name, "_cnt"},  int'(cnt_o),  c);
      chk({name, "_tc"},   int'(tc_o),   t);
      chk({name, "_busy"}, int'(busy_o), b);
      $display("%s: cnt=%0d tc=%0d busy=%0d", name, cnt_o, tc_o, busy_o);
   endtask

   initial begin
      int tc_seen;
      int exp_cnt[8];
      int exp_tc[8];

      // Reset held for two edges, then a load attempt while reset is still low
      cyc(0, 0, 0, 0); pin("rst0", 0, 0, 0);
      cyc(0, 0, 0, 0); pin("rst1", 0, 0, 0);
      cyc(0, 1, 5, 1); pin("rst_load", 0, 0, 0);
      cyc(1, 0, 0, 1); pin("idle_after_rst", 0, 0, 0);

      // Load 3, then count down continuously
      cyc(1, 1, 3, 1); pin("ld3", 3, 0, 1);
      cyc(1, 0, 0, 1); pin("ld3_a", 2, 0, 1);
      cyc(1, 0, 0, 1); pin("ld3_b", 1, 0, 1);
`ifndef DOWN_COUNTER_AUTORELOAD_EN
      cyc(1, 0, 0, 1); pin("ld3_c", 0, 1, 0);
      cyc(1, 0, 0, 1); pin("ld3_d", 0, 0, 0);
      cyc(1, 0, 0, 1); pin("ld3_e", 0, 0, 0);
`else
      cyc(1, 0, 0, 1); pin("ld3_c", 0, 1, 1);
      cyc(1, 0, 0, 1); pin("ld3_d", 3, 0, 1);
      cyc(0, 0, 0, 0); pin("ld3_rst", 0, 0, 0);
`endif

      // Load 9, two decrements, then a restart with 4
      exp_cnt = '{9, 8, 7, 4, 3, 2, 1, 0};
      exp_tc  = '{0, 0, 0, 0, 0, 0, 0, 1};
      tc_seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 0)      cyc(1, 1, 9, 1);
         else if (i == 3) cyc(1, 1, 4, 1);
         else             cyc(1, 0, 0, 1);
         tc_seen += int'(tc_o);
         chk("restart_cnt", int'(cnt_o), exp_cnt[i]);
         chk("restart_tc",  int'(tc_o),  exp_tc[i]);
         $display("restart step %0d: cnt=%0d tc=%0d", i, cnt_o, tc_o);
      end
      chk("restart_tc_pulses", tc_seen, 1);

      // Load 0: immediate terminal pulse, no run
      cyc(1, 1, 0, 1); pin("ld0", 0, 1, 0);
      cyc(1, 0, 0, 1); pin("ld0_after", 0, 0, 0);

      // Load 15, enable toggling: 15 enabled edges in 30 cycles
      cyc(1, 1, 15, 0); pin("ld15", 15, 0, 1);
      tc_seen = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(1, 0, 0, (i % 2) == 0);
         tc_seen += int'(tc_o);
         $display("toggle step %0d: en=%0d cnt=%0d tc=%0d", i, en_i, cnt_o, tc_o);
      end
      chk("toggle_tc_pulses", tc_seen, 1);
      chk("toggle_end_cnt", int'(cnt_o), 0);

      // Reset in the middle of a countdown aborts it with no pulse
      cyc(1, 1, 6, 1); pin("abort_ld", 6, 0, 1);
      cyc(1, 0, 0, 1); pin("abort_dec", 5, 0, 1);
      cyc(0, 0, 0, 1); pin("abort_rst", 0, 0, 0);
      cyc(1, 0, 0, 1); pin("abort_idle", 0, 0, 0);

`ifdef DOWN_COUNTER_AUTORELOAD_EN
      // Auto-reload: load 2 with enable held high for 9 edges
      tc_seen = 0;
      for (int i = 0; i < 9; i++) begin
         cyc(1, i == 0, 2, 1);
         tc_seen += int'(tc_o);
         chk("auto_cnt",  int'(cnt_o),  2 - (i % 3));
         chk("auto_busy", int'(busy_o), 1);
         $display("auto step %0d: cnt=%0d tc=%0d busy=%0d", i, cnt_o, tc_o, busy_o);
      end
      chk("auto_tc_pulses", tc_seen, 3);
`endif

      // Randomized phase checked by the model on every cycle
      for (int i = 0; i < 600; i++) begin
         cyc($urandom_range(0, 19) != 0,
             $urandom_range(0, 9) == 0,
             int'($urandom_range(0, 15)),
             $urandom_range(0, 9) < 7);
         $display("rand %0d: rst_n=%0d ld=%0d val=%0d en=%0d -> cnt=%0d tc=%0d busy=%0d",
                  i, n_rst_i, load_i, load_val_i, en_i, cnt_o, tc_o, busy_o);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule
